// File: rtl/imem_loader.sv
// imem_loader: streams a little-endian byte sequence into a 32-bit instruction memory.
// Each group of four bytes becomes one word, written at consecutive word-aligned addresses.
// The core is held (cpu_hold) for the whole session. done pulses once when a session
// finishes normally. An abort ends the session early, without done.
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             abort,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ZERO_L  = {LEN_W{1'b0}};

  // Places one byte into the selected lane of the word being assembled.
  function automatic logic [31:0] insert_byte(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [7:0]  data
  );
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = data;
      2'd1:    w[15:8]  = data;
      2'd2:    w[23:16] = data;
      2'd3:    w[31:24] = data;
      default: w        = word;
    endcase
    return w;
  endfunction

  // Architectural state
  logic [1:0]       state_r;
  logic [LEN_W-1:0] word_idx_r;
  logic [1:0]       byte_cnt_r;
  logic [31:0]      word_r;
  logic [LEN_W-1:0] len_r;

  // Next-state values
  logic [1:0]       state_s;
  logic [LEN_W-1:0] word_idx_s;
  logic [1:0]       byte_cnt_s;
  logic [31:0]      word_s;
  logic [LEN_W-1:0] len_s;

  // Registered output stage; values reflect the state being entered.
  logic             rdy_r;
  logic             mem_we_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic             busy_r;
  logic             done_r;

  // Next-state decode for the session FSM, the word assembler and the word index.
  always_comb begin
    state_s    = state_r;
    word_idx_s = word_idx_r;
    byte_cnt_s = byte_cnt_r;
    word_s     = word_r;
    len_s      = len_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (load_len == ZERO_L) begin
            state_s = ST_DONE;
          end else begin
            state_s    = ST_RECV;
            len_s      = (load_len > DEPTH_L) ? DEPTH_L : load_len;
            word_idx_s = ZERO_L;
            byte_cnt_s = 2'd0;
            word_s     = 32'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (abort) begin
          // Abort wins over a byte offered in the same cycle; partial word is dropped.
          state_s    = ST_IDLE;
          byte_cnt_s = 2'd0;
          word_s     = 32'd0;
        end else if (byte_valid) begin
          word_s     = insert_byte(word_r, byte_cnt_r, byte_data);
          byte_cnt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_RECV;
          end
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_WRITE: begin
        // The write itself is already on the output registers; abort only
        // changes where the FSM goes afterwards.
        word_idx_s = word_idx_r + {{(LEN_W-1){1'b0}}, 1'b1};
        word_s     = 32'd0;
        if (abort) begin
          state_s = ST_IDLE;
        end else if (word_idx_s == len_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s    = ST_IDLE;
        word_idx_s = ZERO_L;
        byte_cnt_s = 2'd0;
        word_s     = 32'd0;
        len_s      = ZERO_L;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      word_idx_r <= ZERO_L;
      byte_cnt_r <= 2'd0;
      word_r     <= 32'd0;
      len_r      <= ZERO_L;
    end else begin
      state_r    <= state_s;
      word_idx_r <= word_idx_s;
      byte_cnt_r <= byte_cnt_s;
      word_r     <= word_s;
      len_r      <= len_s;
    end
  end

  // Output registers loaded from the next state, so they line up with state_r.
  // The address/data bus is forced to zero whenever no write is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_r       <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      rdy_r    <= (state_s == ST_RECV);
      mem_we_r <= (state_s == ST_WRITE);
      if (state_s == ST_WRITE) begin
        mem_addr_r  <= 32'({word_idx_s, 2'b00});
        mem_wdata_r <= word_s;
      end else begin
        mem_addr_r  <= 32'd0;
        mem_wdata_r <= 32'd0;
      end
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_DONE);
    end
  end

  // byte_ready drops in the abort cycle so the offered byte is visibly refused.
  assign byte_ready = rdy_r & ~abort;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;
  assign cpu_hold   = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Sessions are driven with random bytes and random
// gaps. The expected memory image is rebuilt from the byte stream: word i sits at address
// 4*i and holds bytes 4i..4i+3, little-endian. Directed steps cover abort, reset and the
// ignored-input cases.
module tb_imem_loader;
  localparam int DEPTH = 16;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] load_len;
  logic             abort;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             cpu_hold;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  // Observation side: records what the DUT did, for later comparison.
  int          cyc = 0;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          we_cyc[$];
  int          done_n = 0;
  int          done_cyc = 0;
  int          hold_rises = 0;
  int          bus_bad = 0;
  int          hold_bad = 0;
  logic        prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      we_cyc.push_back(cyc);
    end else if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      bus_bad <= bus_bad + 1;
    end
    if (done === 1'b1) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (cpu_hold !== busy) hold_bad <= hold_bad + 1;
    if (busy === 1'b1 && prev_busy !== 1'b1) hold_rises <= hold_rises + 1;
    prev_busy <= busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte after an idle gap; ok reports whether it was accepted in time.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      if (byte_ready === 1'b1) ok = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
  endtask

  // Full session: start, feed min(len,DEPTH)*4 bytes, wait for done, compare memory image.
  task automatic run_session(input int len, input int gapmax, input int glitch_at,
                             input bit use_fixed, input logic [31:0] fixed_word,
                             input string tag);
    int          n;
    int          ob;
    int          db;
    int          hb;
    int          to;
    int          gap;
    bit          ok;
    logic [7:0]  b;
    logic [7:0]  bts[$];
    logic [31:0] expw;
    n  = (len > DEPTH) ? DEPTH : len;
    ob = obs_addr.size();
    db = done_n;
    hb = hold_rises;
    start    = 1'b1;
    load_len = LEN_W'(len);
    tick();
    start = 1'b0;
    #1;
    check({tag, " hold_after_start"}, 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 4 * n; i++) begin
      if (i == glitch_at) begin
        start    = 1'b1;
        load_len = 5'd3;
        tick();
        start = 1'b0;
      end
      if (use_fixed) b = fixed_word[8 * (i % 4) +: 8];
      else           b = 8'($urandom);
      bts.push_back(b);
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      send_byte(b, gap, ok);
      if (!ok) begin
        check({tag, " byte_accept_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
    to = 0;
    while (done_n == db && to < 20) begin
      tick();
      to++;
    end
    tick();
    check({tag, " done_pulses"}, 32'(done_n - db), 32'd1);
    check({tag, " write_count"}, 32'(obs_addr.size() - ob), 32'(n));
    for (int i = 0; i < n && (ob + i) < obs_addr.size(); i++) begin
      expw = {bts[4*i+3], bts[4*i+2], bts[4*i+1], bts[4*i]};
      check($sformatf("%s addr[%0d]", tag, i), obs_addr[ob+i], 32'(4 * i));
      check($sformatf("%s data[%0d]", tag, i), obs_data[ob+i], expw);
    end
    if (n > 0 && we_cyc.size() > 0)
      check({tag, " done_after_write"}, 32'(done_cyc - we_cyc[we_cyc.size()-1]), 32'd1);
    check({tag, " hold_continuous"}, 32'(hold_rises - hb), 32'd1);
    check({tag, " idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  ob;
    int  db;
    bit  ok;
    logic [7:0]  w0[4];
    logic [31:0] expw;
    reset      = 1'b1;
    start      = 1'b0;
    load_len   = 5'd0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    tick();
    tick();
    check("rst byte_ready", 32'(byte_ready), 32'd0);
    check("rst mem_we",     32'(mem_we),     32'd0);
    check("rst mem_addr",   mem_addr,        32'd0);
    check("rst mem_wdata",  mem_wdata,       32'd0);
    check("rst cpu_hold",   32'(cpu_hold),   32'd0);
    check("rst busy",       32'(busy),       32'd0);
    check("rst done",       32'(done),       32'd0);
    reset = 1'b0;
    tick();

    // Single word, back-to-back bytes 0x33,0x02,0x11,0x00.
    run_session(1, 0, -1, 1'b1, 32'h0011_0233, "len1");
    check("len1 literal_word", obs_data[obs_data.size()-1], 32'h0011_0233);

    // Three words with random gaps.
    run_session(3, 3, -1, 1'b0, 32'd0, "len3_gaps");

    // Zero length goes straight to DONE without writes.
    run_session(0, 0, -1, 1'b0, 32'd0, "len0");

    // Oversized request is clamped to DEPTH words.
    run_session(20, 1, -1, 1'b0, 32'd0, "len20");
    check("len20 last_addr", obs_addr[obs_addr.size()-1], 32'h0000_003C);

    // Abort after two bytes of the second word.
    ob = obs_addr.size();
    db = done_n;
    start    = 1'b1;
    load_len = 5'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w0[i] = 8'($urandom);
      send_byte(w0[i], 0, ok);
    end
    for (int i = 0; i < 2; i++) send_byte(8'($urandom), 1, ok);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    abort      = 1'b1;
    #1;
    check("abort_recv byte_ready", 32'(byte_ready), 32'd0);
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("abort_recv idle", 32'(busy), 32'd0);
    repeat (4) tick();
    expw = {w0[3], w0[2], w0[1], w0[0]};
    check("abort_recv writes", 32'(obs_addr.size() - ob), 32'd1);
    check("abort_recv word0", obs_data[ob], expw);
    check("abort_recv no_done", 32'(done_n - db), 32'd0);
    run_session(1, 0, -1, 1'b0, 32'd0, "after_abort");

    // Abort while the write strobe is up: write completes, no done.
    ob = obs_addr.size();
    db = done_n;
    start    = 1'b1;
    load_len = 5'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0, ok);
    abort = 1'b1;
    #1;
    check("abort_write we", 32'(mem_we), 32'd1);
    tick();
    abort = 1'b0;
    #1;
    check("abort_write idle", 32'(busy), 32'd0);
    repeat (4) tick();
    check("abort_write writes", 32'(obs_addr.size() - ob), 32'd1);
    check("abort_write no_done", 32'(done_n - db), 32'd0);

    // Reset during WRITE clears all outputs on the next edge.
    db = done_n;
    start    = 1'b1;
    load_len = 5'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0, ok);
    reset = 1'b1;
    #1;
    check("rst_write we_before", 32'(mem_we), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("rst_write mem_we",   32'(mem_we),   32'd0);
    check("rst_write mem_addr", mem_addr,      32'd0);
    check("rst_write wdata",    mem_wdata,     32'd0);
    check("rst_write hold",     32'(cpu_hold), 32'd0);
    check("rst_write busy",     32'(busy),     32'd0);
    check("rst_write ready",    32'(byte_ready), 32'd0);
    repeat (3) tick();
    check("rst_write no_done", 32'(done_n - db), 32'd0);

    // byte_valid while idle has no effect on state or the next session.
    ob = obs_addr.size();
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) tick();
    #1;
    check("idle_valid busy",  32'(busy),       32'd0);
    check("idle_valid ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    tick();
    check("idle_valid writes", 32'(obs_addr.size() - ob), 32'd0);
    run_session(1, 0, -1, 1'b0, 32'd0, "after_idle_valid");

    // start pulsed mid-session is ignored.
    run_session(1, 0, 2, 1'b0, 32'd0, "start_in_recv");

    check("bus_zero_when_idle", 32'(bus_bad), 32'd0);
    check("hold_equals_busy",   32'(hold_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 16: number of 32-bit words in the target instruction memory.
REQ-002 Parameter LEN_W, default 5: width of load_len, equal to $clog2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a load session; sampled only in IDLE.
REQ-006 load_len  input  LEN_W  number of words to load; sampled with start.
REQ-007 abort  input  1  cancel the session in progress.
REQ-008 byte_valid  input  1  byte_data is valid.
REQ-009 byte_data  input  8  instruction byte stream, little-endian within each word.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_we  output  1  instruction-memory write strobe.
REQ-012 mem_addr  output  32  byte address, word-aligned (word index << 2), matching the fetch-side addr[31:2] indexing.
REQ-013 mem_wdata  output  32  assembled instruction word.
REQ-014 cpu_hold  output  1  holds the core (PC/fetch) while a session is active.
REQ-015 busy  output  1  session active.
REQ-016 done  output  1  one-cycle pulse when a session completes normally.

Function
REQ-017 The FSM SHALL have four states: IDLE, RECV, WRITE, DONE.
REQ-018 IDLE: byte_ready=0, mem_we=0, cpu_hold=0, busy=0, done=0.
REQ-019 IDLE + start: if load_len==0, go to DONE; otherwise latch min(load_len, DEPTH), clear word_idx and byte_cnt, and go to RECV.
REQ-020 start in any state other than IDLE SHALL be ignored.
REQ-021 RECV: byte_ready=1; a byte transfers when byte_valid&&byte_ready.
REQ-022 A transferred byte SHALL be placed at word bits [8*byte_cnt+7 : 8*byte_cnt], and byte_cnt SHALL increment (2-bit, wraps 3->0).
REQ-023 Transfer of the 4th byte (byte_cnt==3) SHALL move the FSM to WRITE on the next edge.
REQ-024 WRITE: mem_we=1 for exactly one cycle, mem_addr={word_idx,2'b00} zero-extended, mem_wdata=assembled word, byte_ready=0.
REQ-025 Leaving WRITE: word_idx increments; if the new word_idx equals the latched length, go to DONE, else go to RECV.
REQ-026 Latency: 4th byte accepted at cycle N -> mem_we at N+1 -> next byte accepted at N+2 at the earliest.
REQ-027 DONE: done=1 and cpu_hold=1 for one cycle, then unconditionally go to IDLE.
REQ-028 busy and cpu_hold SHALL be 1 in RECV, WRITE and DONE; done SHALL be 0 outside DONE.
REQ-029 mem_addr and mem_wdata SHALL be 0 whenever mem_we=0.
REQ-030 abort in RECV SHALL go to IDLE on the next edge, discard any partial word, and suppress done.
REQ-031 abort in WRITE SHALL still complete that cycle's write, then go to IDLE without done.
REQ-032 abort in IDLE or DONE SHALL be ignored; abort has priority over the byte transfer in the same RECV cycle (the byte is not accepted, byte_ready=0).
REQ-033 byte_valid outside RECV SHALL be ignored, and no state SHALL change because of it.

Reset
REQ-034 reset SHALL force IDLE, word_idx=0, byte_cnt=0, word register=0, latched length=0, and all outputs to 0 on the next edge.
REQ-035 reset during any state, including WRITE, SHALL take priority over abort/start/byte_valid; memory contents already written are untouched.

Verification
REQ-036 start, load_len=1, bytes 0x33,0x02,0x11,0x00 back-to-back -> one mem_we, addr 0x0, wdata 0x00110233, done one cycle after the write.
REQ-037 start, load_len=3, 12 bytes with random valid gaps -> writes at addr 0x0, 0x4, 0x8 in order; cpu_hold high from the cycle after start through DONE.
REQ-038 load_len=0 -> DONE the next cycle, no mem_we; load_len=20 -> exactly 16 writes, last addr 0x3C.
REQ-039 abort after 2 bytes of word 1 (load_len=2) -> no second write, no done, IDLE; a new session then starts at addr 0x0 with a fresh byte_cnt.
REQ-040 reset asserted in WRITE -> all outputs 0 next cycle; start during RECV and byte_valid during IDLE -> no effect.
